// File: rtl/pc_unit.sv
// Program counter / fetch sequencer: sequences instruction fetch addresses, handles branch/jalr redirects,
// memory wait states and stalls. Optional macro PC_MISALIGN_TRAP_EN halts on misaligned redirect targets.
module pc_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'hBFC0_0000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCSrc_i,
    input  logic             Jalr_i,
    input  logic [WIDTH-1:0] ImmExt_i,
    input  logic [WIDTH-1:0] ALUResult_i,
    input  logic             stall_i,
    input  logic             imem_ready_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] PC_o,
    output logic [WIDTH-1:0] PCPlus4_o,
    output logic             redirect_o,
    output logic [31:0]      fetch_count_o,
    output logic             misalign_o
);

    typedef enum logic [1:0] {RESET_S, FETCH_S, WAIT_S, HALT_S} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_redirect;
    logic [31:0]      r_fetch_count;
    logic             r_misalign;

    logic             w_req;
    logic             w_accept;
    logic             w_redir_sel;
    logic             w_trap;
    logic [WIDTH-1:0] w_pcplus4;
    logic [WIDTH-1:0] w_raw_target;
    logic [WIDTH-1:0] w_next_pc;

    assign w_req       = (r_state == FETCH_S) || (r_state == WAIT_S);
    assign w_accept    = w_req && imem_ready_i && !stall_i;
    assign w_redir_sel = Jalr_i || PCSrc_i;
    assign w_pcplus4   = r_pc + WIDTH'(4);

    // Jalr wins over a simultaneous branch; jalr target has bit 0 cleared
    assign w_raw_target = Jalr_i ? {ALUResult_i[WIDTH-1:1], 1'b0} : (r_pc + ImmExt_i);

`ifdef PC_MISALIGN_TRAP_EN
    assign w_trap    = w_accept && w_redir_sel && (w_raw_target[1:0] != 2'b00);
    assign w_next_pc = w_redir_sel ? w_raw_target : w_pcplus4;
`else
    assign w_trap    = 1'b0;
    // Without the trap, redirect targets are silently word-aligned
    assign w_next_pc = w_redir_sel ? {w_raw_target[WIDTH-1:2], 2'b00} : w_pcplus4;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RESET_S: w_next_state = FETCH_S;
            FETCH_S, WAIT_S: begin
                if (w_accept)
                    w_next_state = w_trap ? HALT_S : FETCH_S;
                else if (!stall_i && !imem_ready_i)
                    w_next_state = WAIT_S;
            end
            HALT_S:  w_next_state = HALT_S;
            default: w_next_state = RESET_S;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RESET_S;
            r_pc          <= RESET_PC;
            r_redirect    <= 1'b0;
            r_fetch_count <= 32'd0;
            r_misalign    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_redirect <= w_accept && w_redir_sel && !w_trap;
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + 32'd1;
                if (!w_trap)
                    r_pc <= w_next_pc;
            end
            if (w_trap)
                r_misalign <= 1'b1;
        end
    end

    assign imem_req_o    = w_req;
    assign PC_o          = r_pc;
    assign PCPlus4_o     = w_pcplus4;
    assign redirect_o    = r_redirect;
    assign fetch_count_o = r_fetch_count;
    assign misalign_o    = r_misalign;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset sequencing, branch/jalr redirect, wait/stall holding,
// wraparound, asynchronous reset in WAIT_S, and misaligned-target handling (both build options).
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrc_i, Jalr_i, stall_i, imem_ready_i;
    logic [31:0] ImmExt_i, ALUResult_i;
    logic        imem_req_o, redirect_o, misalign_o;
    logic [31:0] PC_o, PCPlus4_o, fetch_count_o;

    int vecs = 0;
    int errs = 0;

    pc_unit dut (
        .clk(clk), .rst(rst), .PCSrc_i(PCSrc_i), .Jalr_i(Jalr_i), .ImmExt_i(ImmExt_i),
        .ALUResult_i(ALUResult_i), .stall_i(stall_i), .imem_ready_i(imem_ready_i),
        .imem_req_o(imem_req_o), .PC_o(PC_o), .PCPlus4_o(PCPlus4_o), .redirect_o(redirect_o),
        .fetch_count_o(fetch_count_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, vectors=%0d", vecs);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; PCSrc_i = 0; Jalr_i = 0; stall_i = 0; imem_ready_i = 1;
        ImmExt_i = '0; ALUResult_i = '0;
        step();
        vecs++; if (PC_o !== 32'hBFC00000 || imem_req_o !== 1'b0 || fetch_count_o !== 32'd0 ||
                    redirect_o !== 1'b0 || misalign_o !== 1'b0) begin
            errs++; $display("FAIL reset_state: pc=%h req=%b cnt=%0d red=%b mis=%b, want bfc00000 0 0 0 0",
                             PC_o, imem_req_o, fetch_count_o, redirect_o, misalign_o);
        end
        rst = 1'b0;
        step();
        vecs++; if (PC_o !== 32'hBFC00000 || imem_req_o !== 1'b1 || fetch_count_o !== 32'd0) begin
            errs++; $display("FAIL reset_exit: pc=%h req=%b cnt=%0d, want bfc00000 1 0", PC_o, imem_req_o, fetch_count_o);
        end
        step();
        vecs++; if (PC_o !== 32'hBFC00004 || PCPlus4_o !== 32'hBFC00008) begin
            errs++; $display("FAIL seq1: pc=%h pc4=%h, want bfc00004 bfc00008", PC_o, PCPlus4_o);
        end
        step();
        vecs++; if (PC_o !== 32'hBFC00008 || fetch_count_o !== 32'd2) begin
            errs++; $display("FAIL seq2: pc=%h cnt=%0d, want bfc00008 2", PC_o, fetch_count_o);
        end
    endtask

    task automatic test_branch();
        step(); step();
        vecs++; if (PC_o !== 32'hBFC00010 || fetch_count_o !== 32'd4) begin
            errs++; $display("FAIL pre_branch: pc=%h cnt=%0d, want bfc00010 4", PC_o, fetch_count_o);
        end
        PCSrc_i = 1'b1; ImmExt_i = 32'hFFFFFFF8;
        step();
        vecs++; if (PC_o !== 32'hBFC00008 || redirect_o !== 1'b1) begin
            errs++; $display("FAIL branch_back: pc=%h red=%b, want bfc00008 1", PC_o, redirect_o);
        end
        PCSrc_i = 1'b0;
        step();
        vecs++; if (PC_o !== 32'hBFC0000C || redirect_o !== 1'b0 || fetch_count_o !== 32'd6) begin
            errs++; $display("FAIL branch_after: pc=%h red=%b cnt=%0d, want bfc0000c 0 6", PC_o, redirect_o, fetch_count_o);
        end
    endtask

    task automatic test_jalr_priority();
        Jalr_i = 1'b1; PCSrc_i = 1'b1; ALUResult_i = 32'h00000101; ImmExt_i = 32'h00000040;
        step();
        vecs++; if (PC_o !== 32'h00000100 || redirect_o !== 1'b1) begin
            errs++; $display("FAIL jalr_prio: pc=%h red=%b, want 00000100 1", PC_o, redirect_o);
        end
        Jalr_i = 1'b0; PCSrc_i = 1'b0;
    endtask

    task automatic test_wait_stall();
        imem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vecs++; if (PC_o !== 32'h00000100 || imem_req_o !== 1'b1 || fetch_count_o !== 32'd7 || redirect_o !== 1'b0) begin
                errs++; $display("FAIL wait_hold%0d: pc=%h req=%b cnt=%0d red=%b, want 00000100 1 7 0",
                                 i, PC_o, imem_req_o, fetch_count_o, redirect_o);
            end
        end
        imem_ready_i = 1'b1;
        step();
        vecs++; if (PC_o !== 32'h00000104 || fetch_count_o !== 32'd8) begin
            errs++; $display("FAIL wait_release: pc=%h cnt=%0d, want 00000104 8", PC_o, fetch_count_o);
        end
        stall_i = 1'b1;
        step();
        vecs++; if (PC_o !== 32'h00000104 || imem_req_o !== 1'b1 || fetch_count_o !== 32'd8) begin
            errs++; $display("FAIL stall_hold: pc=%h req=%b cnt=%0d, want 00000104 1 8", PC_o, imem_req_o, fetch_count_o);
        end
        stall_i = 1'b0;
        step();
        vecs++; if (PC_o !== 32'h00000108 || fetch_count_o !== 32'd9) begin
            errs++; $display("FAIL stall_release: pc=%h cnt=%0d, want 00000108 9", PC_o, fetch_count_o);
        end
    endtask

    task automatic test_wrap();
        Jalr_i = 1'b1; ALUResult_i = 32'hFFFFFFFC;
        step();
        vecs++; if (PC_o !== 32'hFFFFFFFC || PCPlus4_o !== 32'h00000000) begin
            errs++; $display("FAIL wrap_top: pc=%h pc4=%h, want fffffffc 00000000", PC_o, PCPlus4_o);
        end
        Jalr_i = 1'b0;
        step();
        vecs++; if (PC_o !== 32'h00000000 || fetch_count_o !== 32'd11) begin
            errs++; $display("FAIL wrap_zero: pc=%h cnt=%0d, want 00000000 11", PC_o, fetch_count_o);
        end
    endtask

    task automatic test_async_reset();
        imem_ready_i = 1'b0;
        step();
        vecs++; if (imem_req_o !== 1'b1 || PC_o !== 32'h00000000) begin
            errs++; $display("FAIL enter_wait: req=%b pc=%h, want 1 00000000", imem_req_o, PC_o);
        end
        #2 rst = 1'b1;
        #1;
        vecs++; if (PC_o !== 32'hBFC00000 || fetch_count_o !== 32'd0 || imem_req_o !== 1'b0 || redirect_o !== 1'b0) begin
            errs++; $display("FAIL async_reset: pc=%h cnt=%0d req=%b red=%b, want bfc00000 0 0 0",
                             PC_o, fetch_count_o, imem_req_o, redirect_o);
        end
        #1 rst = 1'b0;
        imem_ready_i = 1'b1;
        step();
        vecs++; if (PC_o !== 32'hBFC00000 || imem_req_o !== 1'b1) begin
            errs++; $display("FAIL reset_refetch: pc=%h req=%b, want bfc00000 1", PC_o, imem_req_o);
        end
    endtask

    task automatic test_misalign();
        PCSrc_i = 1'b1; ImmExt_i = 32'h00000006;
        step();
        PCSrc_i = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        vecs++; if (misalign_o !== 1'b1 || imem_req_o !== 1'b0 || PC_o !== 32'hBFC00000) begin
            errs++; $display("FAIL misalign_trap: mis=%b req=%b pc=%h, want 1 0 bfc00000", misalign_o, imem_req_o, PC_o);
        end
        step();
        vecs++; if (misalign_o !== 1'b1 || imem_req_o !== 1'b0 || PC_o !== 32'hBFC00000) begin
            errs++; $display("FAIL halt_stays: mis=%b req=%b pc=%h, want 1 0 bfc00000", misalign_o, imem_req_o, PC_o);
        end
`else
        vecs++; if (misalign_o !== 1'b0 || PC_o !== 32'hBFC00004 || imem_req_o !== 1'b1) begin
            errs++; $display("FAIL misalign_clear: mis=%b pc=%h req=%b, want 0 bfc00004 1", misalign_o, PC_o, imem_req_o);
        end
        step();
        vecs++; if (PC_o !== 32'hBFC00008 || fetch_count_o !== 32'd2) begin
            errs++; $display("FAIL misalign_next: pc=%h cnt=%0d, want bfc00008 2", PC_o, fetch_count_o);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jalr_priority();
        test_wait_stall();
        test_wrap();
        test_async_reset();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
